// File: rtl/axi_mem_slave.sv
// AXI3 slave memory model: one transaction at a time against a word-addressed RAM,
// with a programmable delay from AR handshake to the first read beat.
module axi_mem_slave #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  LAT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WRESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            id_q, id_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            beat_q, beat_d;
    logic [3:0]            lat_q, lat_d;
    logic                  fixed_q, fixed_d;
    logic                  mem_we;

    logic [31:0] mem [DEPTH];

    // Size fields and the aliased/sub-word address bits carry no information here.
    logic unused_ok;
    assign unused_ok = ^{arsize, awsize, araddr[31:ADDR_WIDTH+2], araddr[1:0],
                         awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            fixed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            fixed_q <= fixed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        fixed_d = fixed_q;
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        bvalid  = 1'b0;
        mem_we  = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    arready = 1'b1;
                    awready = !arvalid;
                    if (arvalid) begin
                        id_d    = arid;
                        idx_d   = araddr[ADDR_WIDTH+1:2];
                        len_d   = arlen;
                        fixed_d = (arburst == 2'b00);
                        beat_d  = '0;
                        lat_d   = LAT_INIT;
                        // A latency of one skips the wait state entirely.
                        state_d = (READ_LATENCY <= 1) ? RDATA : RWAIT;
                    end else if (awvalid) begin
                        id_d    = awid;
                        idx_d   = awaddr[ADDR_WIDTH+1:2];
                        len_d   = awlen;
                        fixed_d = (awburst == 2'b00);
                        beat_d  = '0;
                        state_d = WDATA;
                    end
                end
                RWAIT: begin
                    lat_d = lat_q - 4'd1;
                    if (lat_q <= 4'd1) state_d = RDATA;
                end
                RDATA: begin
                    rvalid = 1'b1;
                    rlast  = (beat_q == len_q);
                    if (rready) begin
                        beat_d = beat_q + 4'd1;
                        if (!fixed_q) idx_d = idx_q + 1'b1;
                        if (rlast) state_d = IDLE;
                    end
                end
                WDATA: begin
                    wready = 1'b1;
                    if (wvalid) begin
                        mem_we = 1'b1;
                        beat_d = beat_q + 4'd1;
                        if (!fixed_q) idx_d = idx_q + 1'b1;
                        if (wlast || beat_q == len_q) state_d = WRESP;
                    end
                end
                WRESP: begin
                    bvalid = 1'b1;
                    if (bready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // idx is frozen while a beat waits for rready, so rdata holds naturally.
    assign rdata = rvalid ? mem[idx_q] : 32'h0;
    assign rid   = id_q;
    assign bid   = id_q;
    assign rresp = 2'b00;
    assign bresp = 2'b00;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed + randomized bench for axi_mem_slave against an array-based memory model.
module tb_axi_mem_slave;
    localparam int AW    = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid, arlen, awid, awlen;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;
    logic [3:0]  wstrb;
    logic        arready, rlast, rvalid, awready, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    axi_mem_slave #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] refm [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] addr, input int i, input logic [1:0] burst);
        return int'(((addr >> 2) + ((burst == 2'b00) ? 0 : i)) % DEPTH);
    endfunction

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        awaddr = addr; awlen = len; awburst = burst; awid = id; awsize = 3'd2;
        awvalid = 1'b1;
        #1;
        while (!awready && n < 100) begin tick(); n++; end
        chk("aw_ready", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] addr, input int i, input logic [1:0] burst,
                          input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        int k;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 100) begin tick(); n++; end
        chk("w_ready", {31'b0, wready}, 32'd1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        k = widx(addr, i, burst);
        for (int b = 0; b < 4; b++) if (s[b]) refm[k][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic b_phase(input logic [3:0] id);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 100) begin tick(); n++; end
        chk("b_valid", {31'b0, bvalid}, 32'd1);
        chk("b_id", {28'b0, bid}, {28'b0, id});
        chk("b_resp", {30'b0, bresp}, 32'd0);
        chk("w_closed", {31'b0, wready}, 32'd0);
        tick();
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int nbeats, input bit use_last);
        aw_phase(addr, len, burst, id);
        for (int i = 0; i < nbeats; i++)
            w_beat(addr, i, burst, wd[i], ws[i], use_last && (i == nbeats - 1));
        b_phase(id);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input logic [15:0] stall);
        int n = 0;
        logic [31:0] exp;
        araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd2;
        arvalid = 1'b1;
        #1;
        while (!arready && n < 100) begin tick(); n++; end
        chk("ar_ready", {31'b0, arready}, 32'd1);
        if (awvalid) chk("aw_blocked", {31'b0, awready}, 32'd0);
        tick();
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 64) begin tick(); n++; end
        chk("r_latency", 32'(n), 32'(LAT));
        for (int i = 0; i <= int'(len); i++) begin
            exp = refm[widx(addr, i, burst)];
            if (stall[i]) begin
                rready = 1'b0;
                tick();
                chk("r_hold_valid", {31'b0, rvalid}, 32'd1);
                chk("r_hold_data", rdata, exp);
            end
            rready = 1'b1;
            n = 0;
            while (!rvalid && n < 64) begin tick(); n++; end
            chk("r_data", rdata, exp);
            chk("r_id", {28'b0, rid}, {28'b0, id});
            chk("r_last", {31'b0, rlast}, {31'b0, i == int'(len)});
            chk("r_resp", {30'b0, rresp}, 32'd0);
            tick();
            rready = 1'b0;
        end
        chk("r_done_idle", {31'b0, arready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  l;
        logic [1:0]  bu;
        reset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'd1; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'd1; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        tick(); tick();
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_ids",     {24'b0, rid, bid}, 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_arready", {31'b0, arready}, 32'd1);

        // single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h100, 4'd0, 2'd1, 4'd3, 1, 1'b1);
        do_read(32'h100, 4'd0, 2'd1, 4'd5, 16'h0);

        // byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(32'h200, 4'd0, 2'd1, 4'd1, 1, 1'b1);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(32'h200, 4'd0, 2'd1, 4'd2, 1, 1'b1);
        do_read(32'h200, 4'd0, 2'd1, 4'd2, 16'h0);
        chk("strobe_model", refm[128], 32'h11BB33DD);

        // INCR burst with backpressure, then FIXED read
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h40, 4'd3, 2'd1, 4'd7, 4, 1'b1);
        do_read(32'h40, 4'd3, 2'd1, 4'd9, 16'b1010);
        do_read(32'h40, 4'd2, 2'd0, 4'd4, 16'b0100);

        // wrap at the top word; upper address bits alias
        wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h0000_03FC, 4'd1, 2'd1, 4'd6, 2, 1'b1);
        chk("wrap_model", refm[0], wd[1]);
        do_read(32'hABCD_07FE, 4'd1, 2'd1, 4'd6, 16'b01);

        // early wlast ends the burst; no wlast still stops at len
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(32'h300, 4'd3, 2'd1, 4'd8, 4, 1'b1);
        wd[0] = $urandom; wd[1] = $urandom;
        do_write(32'h300, 4'd3, 2'd1, 4'd8, 2, 1'b1);
        wd[0] = $urandom; wd[1] = $urandom;
        do_write(32'h308, 4'd1, 2'd1, 4'd8, 2, 1'b0);
        do_read(32'h300, 4'd3, 2'd1, 4'd10, 16'h0);

        // simultaneous AR/AW: read first, AW on the first idle cycle after
        awaddr = 32'h280; awlen = 4'd0; awburst = 2'd1; awid = 4'd12; awvalid = 1'b1;
        do_read(32'h40, 4'd1, 2'd1, 4'd11, 16'b10);
        chk("aw_after_read", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        wd[0] = 32'hCAFEF00D;
        w_beat(32'h280, 0, 2'd1, wd[0], 4'hF, 1'b1);
        b_phase(4'd12);
        do_read(32'h280, 4'd0, 2'd1, 4'd12, 16'h0);

        // reset after beat 2 of a 4-beat write
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(32'h80, 4'd3, 2'd1, 4'd1, 4, 1'b1);
        aw_phase(32'h80, 4'd3, 2'd1, 4'd2);
        w_beat(32'h80, 0, 2'd1, 32'hB0B0_0001, 4'hF, 1'b0);
        w_beat(32'h80, 1, 2'd1, 32'hB0B0_0002, 4'hF, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_readies", {29'b0, arready, awready, wready}, 32'd0);
        chk("mid_rst_valids",  {29'b0, rvalid, bvalid, rlast}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("post_rst_arready", {31'b0, arready}, 32'd1);
        do_read(32'h80, 4'd3, 2'd1, 4'd3, 16'h0);

        // randomized write/read pairs
        for (int t = 0; t < 10; t++) begin
            a  = $urandom;
            l  = 4'($urandom_range(0, 7));
            bu = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = (bu == 2'd0 && i > 0) ? 4'($urandom) : 4'hF;
            end
            do_write(a, l, bu, 4'($urandom), int'(l) + 1, 1'b1);
            do_read(a, l, bu, 4'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
